// File: rtl/vend_pkg.sv
// Shared coin encoding and payout FSM state type for the vending coin interface.
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PICK,
      ST_ISSUE,
      ST_GAP,
      ST_DONE
   } vend_state_e;

   // {coin, denom} encoding: denom bit selects the coin value.
   localparam logic COIN_ONE = 1'b0;
   localparam logic COIN_TWO = 1'b1;

   localparam int unsigned UNIT_ONE = 1;
   localparam int unsigned UNIT_TWO = 2;

   // Value in units of a coin given its denomination bit.
   function automatic int unsigned coin_units(input logic den);
      return (den == COIN_TWO) ? UNIT_TWO : UNIT_ONE;
   endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// Saturating per-denomination coin stock counter, reloaded to INIT on reset.
module vend_stock_counter #(
   parameter int CNT_W = 6,
   parameter int INIT  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Refill and payout in the same cycle cancel; otherwise clamp at both ends.
   always_comb begin
      cnt_d = cnt_q;
      if (inc && !dec) begin
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc) begin
         if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Stock register, loaded with the initial fill on reset.
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= CNT_W'(INIT);
      else       cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/vend_change_dispenser.sv
// Change/refund payout engine: greedy 2-unit-first coin selection, one hopper
// strobe per coin with ack handshake, jam timeout and shortfall reporting.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W    = 4,
   parameter int CNT_W    = 6,
   parameter int ONE_INIT = 8,
   parameter int TWO_INIT = 8,
   parameter int ACK_TMO  = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   output logic             coin_out,
   output logic             coin_den,
   input  logic             hopper_ack,
   input  logic             refill_one,
   input  logic             refill_two,
   output logic             busy,
   output logic             done,
   output logic             short_err,
   output logic [AMT_W-1:0] unpaid,
   output logic [CNT_W-1:0] cnt_one,
   output logic [CNT_W-1:0] cnt_two
);

   localparam int TMO_W = $clog2(ACK_TMO + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);
   localparam logic [AMT_W-1:0] AMT_TWO  = AMT_W'(UNIT_TWO);

   vend_state_e      state_q, state_d;
   logic [AMT_W-1:0] remaining_q, remaining_d;
   logic             sel_q, sel_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             short_q, short_d;
   logic [AMT_W-1:0] unpaid_q, unpaid_d;
   logic             dec_one, dec_two;
   logic [AMT_W-1:0] coin_amt;

   assign coin_amt = AMT_W'(coin_units(sel_q));

   // Next-state and datapath updates for the payout sequence.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      sel_d       = sel_q;
      tmo_d       = tmo_q;
      short_d     = short_q;
      unpaid_d    = unpaid_q;
      dec_one     = 1'b0;
      dec_two     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            short_d  = 1'b0;
            unpaid_d = '0;
            if (req_valid) begin
               remaining_d = req_amount;
               state_d     = (req_amount == '0) ? ST_DONE : ST_PICK;
            end
         end
         ST_PICK: begin
            tmo_d = '0;
            // Never pay a 2-unit coin against a single remaining unit.
            if (remaining_q >= AMT_TWO && cnt_two != '0) begin
               sel_d   = COIN_TWO;
               state_d = ST_ISSUE;
            end else if (cnt_one != '0) begin
               sel_d   = COIN_ONE;
               state_d = ST_ISSUE;
            end else begin
               short_d  = 1'b1;
               unpaid_d = remaining_q;
               state_d  = ST_DONE;
            end
         end
         ST_ISSUE: begin
            if (hopper_ack) begin
               dec_one     = (sel_q == COIN_ONE);
               dec_two     = (sel_q == COIN_TWO);
               remaining_d = remaining_q - coin_amt;
               tmo_d       = '0;
               state_d     = (remaining_d == '0) ? ST_DONE : ST_GAP;
            end else if (tmo_q == TMO_LAST) begin
               // Hopper jammed: give up with the current coin still counted as unpaid.
               short_d  = 1'b1;
               unpaid_d = remaining_q;
               tmo_d    = '0;
               state_d  = ST_DONE;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_GAP:  state_d = ST_PICK;
         ST_DONE: begin
            remaining_d = '0;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and payout bookkeeping registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         sel_q       <= COIN_ONE;
         tmo_q       <= '0;
         short_q     <= 1'b0;
         unpaid_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         sel_q       <= sel_d;
         tmo_q       <= tmo_d;
         short_q     <= short_d;
         unpaid_q    <= unpaid_d;
      end
   end

   vend_stock_counter #(.CNT_W(CNT_W), .INIT(ONE_INIT)) u_stock_one (
      .clk   (clk),
      .reset (reset),
      .inc   (refill_one),
      .dec   (dec_one),
      .cnt   (cnt_one)
   );

   vend_stock_counter #(.CNT_W(CNT_W), .INIT(TWO_INIT)) u_stock_two (
      .clk   (clk),
      .reset (reset),
      .inc   (refill_two),
      .dec   (dec_two),
      .cnt   (cnt_two)
   );

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign coin_out  = (state_q == ST_ISSUE);
   assign coin_den  = (state_q == ST_ISSUE) ? sel_q : COIN_ONE;
   assign done      = (state_q == ST_DONE);
   assign short_err = (state_q == ST_DONE) && short_q;
   assign unpaid    = (state_q == ST_DONE) ? unpaid_q : '0;

endmodule
